// File: rtl/vga_pkg.sv
// Shared types, timing presets and helpers for the VGA scan-out engine.
package vga_pkg;

    // One axis of video timing, in clocks (horizontal) or lines (vertical).
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    // Complete video mode: horizontal and vertical timing.
    typedef struct packed {
        timing_t h;
        timing_t v;
    } mode_t;

    // Per-pixel control signals travelling down the pipeline next to the RAM read.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
    } vid_ctl_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    localparam mode_t SVGA_800x600_72 = '{
        h: '{active: 800, fp: 56, sync: 120, bp: 64},
        v: '{active: 600, fp: 37, sync: 6,   bp: 23}
    };

    localparam mode_t TEST_8x4 = '{
        h: '{active: 8, fp: 2, sync: 2, bp: 2},
        v: '{active: 4, fp: 1, sync: 1, bp: 1}
    };

    function automatic int unsigned timing_total(input timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old data.
module fb_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 3,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Write port and registered read, block-RAM style (no reset on contents).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_q <= mem[raddr];
    end

    assign rdata = rd_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out engine: programmable timing, double-buffered framebuffer,
// 2-stage read pipeline with sync/de/rgb aligned at the pins.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = SVGA_800x600_72.h.active,
    parameter int unsigned H_FP       = SVGA_800x600_72.h.fp,
    parameter int unsigned H_SYNC     = SVGA_800x600_72.h.sync,
    parameter int unsigned H_BP       = SVGA_800x600_72.h.bp,
    parameter int unsigned V_ACTIVE   = SVGA_800x600_72.v.active,
    parameter int unsigned V_FP       = SVGA_800x600_72.v.fp,
    parameter int unsigned V_SYNC     = SVGA_800x600_72.v.sync,
    parameter int unsigned V_BP       = SVGA_800x600_72.v.bp,
    parameter bit          HS_POL     = 1'b1,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned CW         = 1,
    parameter int unsigned SCALE      = 1,
    parameter int unsigned DOUBLE_BUF = 1,
    localparam int unsigned PW   = 3 * CW,
    localparam int unsigned FB_W = H_ACTIVE / SCALE,
    localparam int unsigned FB_H = V_ACTIVE / SCALE,
    // Coordinate ports are wide enough to carry FB_W / FB_H themselves so that
    // out-of-range writes can be expressed even for power-of-two sizes.
    localparam int unsigned XW   = $clog2(FB_W + 1),
    localparam int unsigned YW   = $clog2(FB_H + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [PW-1:0] wr_data,
    output logic          wr_err,
    input  logic          swap_req,
    output logic          swap_ack,
    output logic          frame_start,
    output logic          line_start,
    output logic          vga_de,
    output logic [PW-1:0] vga_rgb,
    output logic          vga_hs,
    output logic          vga_vs
);

    localparam timing_t     H_TIM    = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t     V_TIM    = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned H_TOT    = timing_total(H_TIM);
    localparam int unsigned V_TOT    = timing_total(V_TIM);
    localparam int unsigned HW       = $clog2(H_TOT);
    localparam int unsigned VW       = $clog2(V_TOT);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned SH       = $clog2(SCALE);
    localparam int unsigned FB_SIZE  = FB_W * FB_H;
    localparam int unsigned DEPTH    = (1 + DOUBLE_BUF) * FB_SIZE;
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam vid_ctl_t CTL_RST = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL, fs: 1'b0, ls: 1'b0};

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    swap_state_t   state_q, state_d;
    logic          front_q, front_d;
    logic          swap_ack_q, swap_ack_d;
    logic          wr_ready_q, wr_ready_d;
    logic          wr_err_q, wr_err_d;
    vid_ctl_t      ctl1_q, ctl1_d;
    vid_ctl_t      ctl2_q, ctl2_d;
    logic [PW-1:0] rgb_q, rgb_d;

    logic [31:0]   hx_c, vx_c;
    logic          active_c;
    logic          hs_act_c, vs_act_c;
    logic [AW-1:0] rd_addr_c;
    logic [AW-1:0] wr_addr_c;
    logic          wr_fire_c, in_range_c, we_c, back_c;
    logic [PW-1:0] ram_rdata;

    // Stage 0: raster counters, h wraps each line and v advances on that wrap.
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == HW'(H_TOT - 1)) begin
            h_d = '0;
            if (v_q == VW'(V_TOT - 1)) begin
                v_d = '0;
            end else begin
                v_d = v_q + VW'(1);
            end
        end
    end

    // Stage 0: region decode and read address (idle address outside active video).
    always_comb begin
        hx_c      = 32'(h_q);
        vx_c      = 32'(v_q);
        active_c  = (hx_c < H_ACTIVE) && (vx_c < V_ACTIVE);
        hs_act_c  = (hx_c >= HS_START) && (hx_c < HS_END);
        vs_act_c  = (vx_c >= VS_START) && (vx_c < VS_END);
        ctl1_d    = '{de: active_c,
                      hs: hs_act_c ? HS_POL : ~HS_POL,
                      vs: vs_act_c ? VS_POL : ~VS_POL,
                      fs: (hx_c == 32'd0) && (vx_c == 32'd0),
                      ls: (hx_c == 32'd0) && (vx_c < V_ACTIVE)};
        rd_addr_c = '0;
        if (active_c) begin
            rd_addr_c = AW'(32'(front_q) * FB_SIZE + (vx_c >> SH) * FB_W + (hx_c >> SH));
        end
    end

    // Write port: accept while no flip is pending, drop and flag out-of-range pixels.
    always_comb begin
        wr_fire_c  = wr_valid && wr_ready_q;
        in_range_c = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
        we_c       = wr_fire_c && in_range_c;
        wr_err_d   = wr_fire_c && !in_range_c;
        back_c     = (DOUBLE_BUF != 0) ? ~front_q : 1'b0;
        wr_addr_c  = AW'(32'(back_c) * FB_SIZE + 32'(wr_y) * FB_W + 32'(wr_x));
    end

    // Swap FSM: flip the front bank on the last pixel of the frame.
    // swap_ack is registered one cycle early so it is high during that last pixel.
    always_comb begin
        state_d = state_q;
        front_d = front_q;
        case (state_q)
            IDLE: begin
                if (swap_req) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (swap_ack_q) begin
                    state_d = IDLE;
                    if (DOUBLE_BUF != 0) begin
                        front_d = ~front_q;
                    end
                end
            end
        endcase
        swap_ack_d = (state_d == PENDING) && (h_d == HW'(H_TOT - 1)) && (v_d == VW'(V_TOT - 1));
        wr_ready_d = (state_d == IDLE);
    end

    // Stage 2: output registers, rgb forced to zero outside active video.
    always_comb begin
        ctl2_d = ctl1_q;
        rgb_d  = ctl1_q.de ? ram_rdata : '0;
    end

    // State and pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q        <= '0;
            v_q        <= '0;
            state_q    <= IDLE;
            front_q    <= 1'b0;
            swap_ack_q <= 1'b0;
            wr_ready_q <= 1'b1;
            wr_err_q   <= 1'b0;
            ctl1_q     <= CTL_RST;
            ctl2_q     <= CTL_RST;
            rgb_q      <= '0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            state_q    <= state_d;
            front_q    <= front_d;
            swap_ack_q <= swap_ack_d;
            wr_ready_q <= wr_ready_d;
            wr_err_q   <= wr_err_d;
            ctl1_q     <= ctl1_d;
            ctl2_q     <= ctl2_d;
            rgb_q      <= rgb_d;
        end
    end

    // Stage 1: framebuffer read.
    fb_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PW),
        .AW    (AW)
    ) u_fb_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (wr_addr_c),
        .wdata (wr_data),
        .raddr (rd_addr_c),
        .rdata (ram_rdata)
    );

    assign wr_ready    = wr_ready_q;
    assign wr_err      = wr_err_q;
    assign swap_ack    = swap_ack_q;
    assign frame_start = ctl2_q.fs;
    assign line_start  = ctl2_q.ls;
    assign vga_de      = ctl2_q.de;
    assign vga_hs      = ctl2_q.hs;
    assign vga_vs      = ctl2_q.vs;
    assign vga_rgb     = rgb_q;

endmodule
